// File: rtl/ds_inst_queue_pkg.sv
// Shared types for the IF->ID instruction queue.
package ds_inst_queue_pkg;

  typedef logic [31:0] virt_t;
  typedef logic [31:0] uint32_t;

  // One fetched instruction as held in the queue.
  typedef struct packed {
    virt_t      pc;
    uint32_t    inst;
    logic       ex;
    logic [4:0] exccode;
  } inst_q_entry_t;

  // WAIT_DS: a taken branch left the queue empty, so the next fetched
  // instruction is its delay slot and must be kept alone.
  typedef enum logic {
    IQ_NORMAL  = 1'b0,
    IQ_WAIT_DS = 1'b1
  } iq_state_t;

endpackage

// File: rtl/ds_inst_queue.sv
// Instruction queue between fetch and decode: multi-lane push, single pop,
// delay-slot tagging, wrong-path squash on taken branch, full flush.
module ds_inst_queue
  import ds_inst_queue_pkg::*;
#(
  parameter  int DEPTH   = 8,
  parameter  int FETCH_W = 2,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  input  logic [$clog2(FETCH_W):0]   in_count,
  input  logic [FETCH_W*32-1:0]      in_pc,
  input  logic [FETCH_W*32-1:0]      in_inst,
  input  logic [FETCH_W-1:0]         in_ex,
  input  logic [FETCH_W*5-1:0]       in_exccode,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  output logic                       out_ex,
  output logic [4:0]                 out_exccode,
  output logic                       out_bd,
  input  logic                       out_ready,
  input  logic                       dec_is_br,
  input  logic                       dec_br_taken,
  input  logic                       flush,
  output logic [CNT_W-1:0]           occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int IC_W  = $clog2(FETCH_W) + 1;

  inst_q_entry_t    mem [DEPTH];

  iq_state_t        state, state_n;
  logic [PTR_W-1:0] head, head_n;
  logic [PTR_W-1:0] tail, tail_n;
  logic [CNT_W-1:0] occ_n;
  logic             bd_pending, bd_n;
  logic [IC_W-1:0]  wr_count;

  logic             push, pop, taken;
  inst_q_entry_t    head_e;

  inst_q_entry_t    lane_data [FETCH_W];
  logic [PTR_W-1:0] lane_idx  [FETCH_W];
  logic             lane_we   [FETCH_W];

  // in_ready is deliberately independent of in_count and of a same-cycle pop.
  assign in_ready  = (occupancy <= CNT_W'(DEPTH - FETCH_W));
  assign out_valid = (occupancy != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign taken     = pop & dec_is_br & dec_br_taken;

  assign head_e      = mem[head];
  assign out_pc      = head_e.pc;
  assign out_inst    = head_e.inst;
  assign out_ex      = head_e.ex;
  assign out_exccode = head_e.exccode;
  assign out_bd      = bd_pending & out_valid;

  // Lane l lands at tail+l when it is among the lanes actually kept.
  for (genvar l = 0; l < FETCH_W; l++) begin : g_lane
    assign lane_we[l]           = (wr_count > IC_W'(l));
    assign lane_idx[l]          = tail + PTR_W'(l);
    assign lane_data[l].pc      = in_pc[32*l +: 32];
    assign lane_data[l].inst    = in_inst[32*l +: 32];
    assign lane_data[l].ex      = in_ex[l];
    assign lane_data[l].exccode = in_exccode[5*l +: 5];
  end

  // Next-state: flush beats everything; a taken branch keeps only its delay slot.
  always_comb begin
    state_n  = state;
    head_n   = head;
    tail_n   = tail;
    occ_n    = occupancy;
    bd_n     = bd_pending;
    wr_count = '0;
    if (flush) begin
      state_n = IQ_NORMAL;
      head_n  = tail;
      occ_n   = '0;
      bd_n    = 1'b0;
    end else begin
      if (pop) begin
        head_n = head + PTR_W'(1);
        // A branch sitting in a delay slot re-arms the tag for its own slot.
        bd_n   = dec_is_br;
      end
      if (taken) begin
        if (occupancy > CNT_W'(1)) begin
          // Delay slot is already queued: drop everything behind it.
          occ_n  = CNT_W'(1);
          tail_n = head + PTR_W'(2);
        end else if (push) begin
          wr_count = IC_W'(1);
          tail_n   = tail + PTR_W'(1);
          occ_n    = CNT_W'(1);
        end else begin
          state_n = IQ_WAIT_DS;
          occ_n   = '0;
        end
      end else if (push) begin
        if (state == IQ_WAIT_DS) begin
          wr_count = IC_W'(1);
          state_n  = IQ_NORMAL;
        end else begin
          wr_count = in_count;
        end
        tail_n = tail + PTR_W'(wr_count);
        occ_n  = occupancy + CNT_W'(wr_count) - CNT_W'(pop);
      end else begin
        occ_n = occupancy - CNT_W'(pop);
      end
    end
  end

  // Control registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IQ_NORMAL;
      head       <= '0;
      tail       <= '0;
      occupancy  <= '0;
      bd_pending <= 1'b0;
    end else begin
      state      <= state_n;
      head       <= head_n;
      tail       <= tail_n;
      occupancy  <= occ_n;
      bd_pending <= bd_n;
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    for (int l = 0; l < FETCH_W; l++) begin
      if (lane_we[l]) mem[lane_idx[l]] <= lane_data[l];
    end
  end

  // A valid fetch beat must carry between 1 and FETCH_W lanes.
  assert property (@(posedge clk) disable iff (!resetn)
    in_valid |-> (in_count != '0 && in_count <= IC_W'(FETCH_W)));

endmodule

// File: tb/tb_ds_inst_queue.sv
// Scoreboard bench for ds_inst_queue (DEPTH=8, FETCH_W=2).
module tb_ds_inst_queue;
  import ds_inst_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int FW    = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [1:0]  in_count;
  logic [63:0] in_pc;
  logic [63:0] in_inst;
  logic [1:0]  in_ex;
  logic [9:0]  in_exccode;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ex;
  logic [4:0]  out_exccode;
  logic        out_bd;
  logic        out_ready;
  logic        dec_is_br;
  logic        dec_br_taken;
  logic        flush;
  logic [3:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard state
  inst_q_entry_t sb[$];
  bit            m_bd;
  bit            m_wait;

  ds_inst_queue #(.DEPTH(DEPTH), .FETCH_W(FW)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_count(in_count),
    .in_pc(in_pc), .in_inst(in_inst), .in_ex(in_ex), .in_exccode(in_exccode),
    .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_inst(out_inst), .out_ex(out_ex), .out_exccode(out_exccode),
    .out_bd(out_bd), .out_ready(out_ready), .dec_is_br(dec_is_br),
    .dec_br_taken(dec_br_taken), .flush(flush), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic inst_q_entry_t mk(input logic [31:0] pc);
    inst_q_entry_t e;
    e.pc      = pc;
    e.inst    = {pc[15:0], ~pc[15:0]};
    e.ex      = pc[3];
    e.exccode = pc[8:4];
    return e;
  endfunction

  // One clock: drive inputs after negedge, check against model, update model.
  task automatic cycle(input bit v, input int cnt, input logic [31:0] pc0,
                       input bit rdy, input bit isbr, input bit tk, input bit fl);
    bit m_rdy, m_vld, push, pop;
    inst_q_entry_t e;
    in_valid = v;
    in_count = cnt[1:0];
    for (int l = 0; l < FW; l++) begin
      e = mk(pc0 + 32'(4 * l));
      in_pc[32*l +: 32]     = e.pc;
      in_inst[32*l +: 32]   = e.inst;
      in_ex[l]              = e.ex;
      in_exccode[5*l +: 5]  = e.exccode;
    end
    out_ready    = rdy;
    dec_is_br    = isbr;
    dec_br_taken = tk;
    flush        = fl;
    #1;
    m_rdy = (DEPTH - sb.size()) >= FW;
    m_vld = sb.size() != 0;
    n_checks++;
    if (occupancy !== 4'(sb.size())) begin
      n_fail++; $display("FAIL sb_occupancy: got %0d want %0d", occupancy, sb.size());
    end
    n_checks++;
    if (in_ready !== m_rdy) begin
      n_fail++; $display("FAIL sb_in_ready: got %0b want %0b", in_ready, m_rdy);
    end
    n_checks++;
    if (out_valid !== m_vld) begin
      n_fail++; $display("FAIL sb_out_valid: got %0b want %0b", out_valid, m_vld);
    end
    push = v & m_rdy;
    pop  = m_vld & rdy;
    if (pop) begin
      e = sb[0];
      n_checks++;
      if ({out_pc, out_inst, out_ex, out_exccode} !== {e.pc, e.inst, e.ex, e.exccode}) begin
        n_fail++;
        $display("FAIL sb_head: got pc=%h inst=%h ex=%0b code=%0d want pc=%h inst=%h ex=%0b code=%0d",
                 out_pc, out_inst, out_ex, out_exccode, e.pc, e.inst, e.ex, e.exccode);
      end
      n_checks++;
      if (out_bd !== m_bd) begin
        n_fail++; $display("FAIL sb_bd pc=%h: got %0b want %0b", e.pc, out_bd, m_bd);
      end
    end
    if (fl) begin
      sb.delete(); m_bd = 0; m_wait = 0;
    end else begin
      if (pop) begin
        void'(sb.pop_front());
        m_bd = isbr;
      end
      if (pop && isbr && tk) begin
        if (sb.size() >= 1) begin
          while (sb.size() > 1) void'(sb.pop_back());
        end else if (push) begin
          sb.push_back(mk(pc0));
        end else begin
          m_wait = 1;
        end
      end else if (push) begin
        if (m_wait) begin
          sb.push_back(mk(pc0));
          m_wait = 0;
        end else begin
          for (int l = 0; l < cnt; l++) sb.push_back(mk(pc0 + 32'(4 * l)));
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_count = 2'd1; in_pc = '0; in_inst = '0; in_ex = '0;
    in_exccode = '0; out_ready = 0; dec_is_br = 0; dec_br_taken = 0; flush = 0;
  endtask

  task automatic do_reset(input int n);
    resetn = 0;
    idle_inputs();
    repeat (n) @(posedge clk);
    @(negedge clk);
    resetn = 1;
    sb.delete(); m_bd = 0; m_wait = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && sb.size() != 0; i++) cycle(0, 1, 0, 1, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset(2);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_checks++;
    if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    n_checks++;
    if (out_bd !== 1'b0) begin n_fail++; $display("FAIL reset_out_bd: got %0b want 0", out_bd); end
  endtask

  task automatic test_first_push();
    cycle(1, 2, 32'hBFC0_0000, 0, 0, 0, 0);
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hBFC0_0000) begin
      n_fail++; $display("FAIL first_head: got valid=%0b pc=%h want 1 bfc00000", out_valid, out_pc);
    end
    n_checks++;
    if (occupancy !== 4'd2 || out_bd !== 1'b0) begin
      n_fail++; $display("FAIL first_occ_bd: got occ=%0d bd=%0b want 2 0", occupancy, out_bd);
    end
    drain();
  endtask

  task automatic test_fill();
    for (int b = 0; b < 3; b++) cycle(1, 2, 32'h1000 + 32'(8 * b), 0, 0, 0, 0);
    n_checks++;
    if (occupancy !== 4'd6 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL fill_six: got occ=%0d rdy=%0b want 6 1", occupancy, in_ready);
    end
    cycle(1, 2, 32'h1018, 0, 0, 0, 0);
    n_checks++;
    if (occupancy !== 4'd8 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_full: got occ=%0d rdy=%0b want 8 0", occupancy, in_ready);
    end
    cycle(1, 2, 32'h2000, 0, 0, 0, 0);   // refused while full
    n_checks++;
    if (occupancy !== 4'd8) begin n_fail++; $display("FAIL full_push_ignored: got %0d want 8", occupancy); end
    cycle(0, 1, 0, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 0, 0, 0);
    cycle(1, 2, 32'h1020, 1, 0, 0, 0);   // push+pop at six
    n_checks++;
    if (occupancy !== 4'd7) begin n_fail++; $display("FAIL push_pop_six: got %0d want 7", occupancy); end
    drain();
  endtask

  task automatic test_branch_taken();
    cycle(1, 2, 32'h100, 0, 0, 0, 0);
    cycle(1, 2, 32'h108, 0, 0, 0, 0);
    cycle(1, 2, 32'h300, 1, 1, 1, 0);    // taken beq; same-cycle push discarded
    n_checks++;
    if (occupancy !== 4'd1 || out_pc !== 32'h104 || out_bd !== 1'b1) begin
      n_fail++; $display("FAIL br_squash: got occ=%0d pc=%h bd=%0b want 1 104 1", occupancy, out_pc, out_bd);
    end
    cycle(1, 2, 32'h310, 1, 0, 0, 0);    // pop delay slot, push next beat
    n_checks++;
    if (occupancy !== 4'd2 || out_pc !== 32'h310 || out_bd !== 1'b0) begin
      n_fail++; $display("FAIL br_after_slot: got occ=%0d pc=%h bd=%0b want 2 310 0", occupancy, out_pc, out_bd);
    end
    drain();
  endtask

  task automatic test_wait_ds();
    cycle(1, 1, 32'h200, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 1, 1, 0);          // taken, queue empties, no push
    n_checks++;
    if (out_valid !== 1'b0 || out_bd !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL waitds_empty: got v=%0b bd=%0b rdy=%0b want 0 0 1", out_valid, out_bd, in_ready);
    end
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(1, 2, 32'h204, 0, 0, 0, 0);
    n_checks++;
    if (occupancy !== 4'd1 || out_pc !== 32'h204 || out_bd !== 1'b1) begin
      n_fail++; $display("FAIL waitds_push: got occ=%0d pc=%h bd=%0b want 1 204 1", occupancy, out_pc, out_bd);
    end
    drain();
  endtask

  task automatic test_taken_single_push();
    cycle(1, 1, 32'h400, 0, 0, 0, 0);
    cycle(1, 2, 32'h404, 1, 1, 1, 0);    // taken with push: keep lane 0 only
    n_checks++;
    if (occupancy !== 4'd1 || out_pc !== 32'h404 || out_bd !== 1'b1) begin
      n_fail++; $display("FAIL taken_push: got occ=%0d pc=%h bd=%0b want 1 404 1", occupancy, out_pc, out_bd);
    end
    drain();
  endtask

  task automatic test_flush();
    cycle(1, 2, 32'h700, 0, 0, 0, 0);
    cycle(1, 2, 32'h708, 0, 0, 0, 0);
    cycle(1, 1, 32'h710, 0, 0, 0, 0);
    n_checks++;
    if (occupancy !== 4'd5) begin n_fail++; $display("FAIL flush_setup: got %0d want 5", occupancy); end
    cycle(1, 2, 32'h800, 1, 1, 0, 1);
    n_checks++;
    if (occupancy !== 4'd0 || out_valid !== 1'b0 || out_bd !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear: got occ=%0d v=%0b bd=%0b want 0 0 0", occupancy, out_valid, out_bd);
    end
    cycle(1, 2, 32'h900, 0, 0, 0, 0);
    n_checks++;
    if (out_valid !== 1'b1 || out_bd !== 1'b0 || out_pc !== 32'h900) begin
      n_fail++; $display("FAIL flush_refill: got v=%0b bd=%0b pc=%h want 1 0 900", out_valid, out_bd, out_pc);
    end
    drain();
  endtask

  task automatic test_reset_wait_ds();
    cycle(1, 1, 32'h600, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 1, 1, 0);          // into WAIT_DS with bd pending
    do_reset(1);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 4'd0) begin
      n_fail++; $display("FAIL rst_waitds: got v=%0b rdy=%0b occ=%0d want 0 1 0", out_valid, in_ready, occupancy);
    end
    cycle(1, 2, 32'h500, 0, 0, 0, 0);
    n_checks++;
    if (occupancy !== 4'd2 || out_bd !== 1'b0) begin
      n_fail++; $display("FAIL rst_both_lanes: got occ=%0d bd=%0b want 2 0", occupancy, out_bd);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      bit isbr;
      isbr = ($urandom_range(0, 3) == 0);
      cycle(bit'($urandom_range(0, 1)), int'($urandom_range(1, 2)),
            $urandom & 32'hFFFF_FFF0, ($urandom_range(0, 2) != 0), isbr,
            isbr & bit'($urandom_range(0, 1)), ($urandom_range(0, 30) == 0));
    end
    drain();
  endtask

  initial begin
    resetn = 0;
    idle_inputs();
    m_bd = 0; m_wait = 0;
    @(negedge clk);
    test_reset();
    test_first_push();
    test_fill();
    test_branch_taken();
    test_wait_ds();
    test_taken_single_push();
    test_flush();
    test_reset_wait_ds();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
